// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline-stage register.
// The state code doubles as the occupancy count exported by each stage.
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage : pipe_pkg

// File: rtl/register_n.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
module register_n #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register_n

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register: main register plus one-entry skid buffer, giving full
// throughput with in_ready driven only from registered state.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_t           state;
  state_t           state_next;
  logic             acc_in;
  logic             acc_out;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign count     = state;

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    main_d     = in_data;

    if (flush) begin
      // A same-cycle acc_out is still a delivery; the incoming beat is dropped.
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc_in) begin
            state_next = BUSY;
            main_en    = 1'b1;
          end
        end
        BUSY: begin
          if (acc_in && acc_out) begin
            main_en = 1'b1;
          end else if (acc_in) begin
            state_next = FULL;
            skid_en    = 1'b1;
          end else if (acc_out) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (acc_out) begin
            state_next = BUSY;
            main_en    = 1'b1;
            main_d     = skid_q;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  register_n #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  register_n #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a 64-bit stage for directed and random
// traffic and a 1-bit stage for random traffic, each against a queue model.
module tb_pipe_stage_reg;

  localparam logic [63:0] A_RST = 64'hDEAD_BEEF_0000_5A5A;
  localparam logic        B_RST = 1'b1;
  localparam int          N_RAND = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_in_data, b_out_data;
  logic [1:0]  b_count;

  pipe_stage_reg #(.WIDTH(64), .RESET_VAL(A_RST)) dut_a (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .count     (a_count)
  );

  pipe_stage_reg #(.WIDTH(1), .RESET_VAL(B_RST)) dut_b (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .count     (b_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] qa[$];
  logic        qb[$];
  int sent_a, sent_b, got_a, got_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs on stage A (called just after a falling edge),
  // compare state against the model, then advance the model for the coming edge.
  task automatic drive_a(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    int          sz;
    logic [63:0] exp;
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    a_flush     = fl;
    sz = qa.size();
    check("a_count", 64'(a_count), 64'(sz));
    check("a_out_valid", 64'(a_out_valid), 64'(sz != 0));
    check("a_in_ready", 64'(a_in_ready), 64'(sz < 2));
    if (sz != 0 && ordy) begin
      exp = qa.pop_front();
      check("a_data", a_out_data, exp);
      got_a++;
    end
    if (fl) begin
      qa.delete();
    end else if (iv && sz < 2) begin
      qa.push_back(d);
      sent_a++;
    end
  endtask

  task automatic drive_b(input logic iv, input logic d, input logic ordy, input logic fl);
    int   sz;
    logic exp;
    b_in_valid  = iv;
    b_in_data   = d;
    b_out_ready = ordy;
    b_flush     = fl;
    sz = qb.size();
    check("b_count", 64'(b_count), 64'(sz));
    check("b_out_valid", 64'(b_out_valid), 64'(sz != 0));
    check("b_in_ready", 64'(b_in_ready), 64'(sz < 2));
    if (sz != 0 && ordy) begin
      exp = qb.pop_front();
      check("b_data", 64'(b_out_data), 64'(exp));
      got_b++;
    end
    if (fl) begin
      qb.delete();
    end else if (iv && sz < 2) begin
      qb.push_back(d);
      sent_b++;
    end
  endtask

  initial begin
    int cyc;
    logic iv;
    logic ordy;

    clr_n = 1'b0;
    {a_flush, a_in_valid, a_out_ready} = '0;
    {b_flush, b_in_valid, b_out_ready, b_in_data} = '0;
    a_in_data = '0;
    sent_a = 0; sent_b = 0; got_a = 0; got_b = 0;

    repeat (2) @(negedge clk);
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_ready", 64'(a_in_ready), 64'd1);
    check("rst_a_count", 64'(a_count), 64'd0);
    check("rst_a_data", a_out_data, A_RST);
    check("rst_b_data", 64'(b_out_data), 64'(B_RST));
    clr_n = 1'b1;

    // Streaming with out_ready high: 1..8, no bubbles.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      drive_a(1'b1, 64'(i), 1'b1, 1'b0);
    end
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);
    check("a_hold_empty", a_out_data, 64'h8);

    // Stall and skid: A, B accepted, C held upstream, then released in order.
    @(negedge clk); drive_a(1'b1, 64'hA, 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b1, 64'hB, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk); drive_a(1'b1, 64'hC, 1'b0, 1'b0);
    end
    @(negedge clk); drive_a(1'b1, 64'hC, 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b1, 64'hC, 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);

    // Flush in FULL with a same-cycle input beat that must vanish.
    @(negedge clk); drive_a(1'b1, 64'h10, 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b1, 64'h11, 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b1, 64'hD, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);
    end

    // Flush in BUSY with simultaneous drain: 0xE delivered once.
    @(negedge clk); drive_a(1'b1, 64'hE, 1'b0, 1'b0);
    got_a = 0;
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b1);
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);
    check("a_flush_drain_once", 64'(got_a), 64'd1);

    // Asynchronous reset while FULL.
    @(negedge clk); drive_a(1'b1, 64'h20, 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b1, 64'h21, 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b0, '0, 1'b0, 1'b0);
    #2 clr_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_ready", 64'(a_in_ready), 64'd1);
    check("mid_rst_count", 64'(a_count), 64'd0);
    check("mid_rst_data", a_out_data, A_RST);
    qa.delete();
    @(negedge clk);
    clr_n = 1'b1;

    // Randomised back-pressure on both widths.
    sent_a = 0; sent_b = 0; got_a = 0; got_b = 0;
    cyc = 0;
    while ((got_a < N_RAND || got_b < N_RAND) && cyc < 20000) begin
      @(negedge clk);
      iv   = (sent_a < N_RAND) && ($urandom_range(0, 3) != 0);
      ordy = (sent_a >= N_RAND) || ($urandom_range(0, 2) != 0);
      drive_a(iv, {$urandom, $urandom}, ordy, 1'b0);
      check("a_no_ready_full", 64'(a_in_ready && a_count == 2'd2), 64'd0);
      iv   = (sent_b < N_RAND) && ($urandom_range(0, 1) != 0);
      ordy = (sent_b >= N_RAND) || ($urandom_range(0, 1) != 0);
      drive_b(iv, 1'($urandom), ordy, 1'b0);
      check("b_no_ready_full", 64'(b_in_ready && b_count == 2'd2), 64'd0);
      cyc++;
    end
    check("rand_a_delivered", 64'(got_a), 64'(N_RAND));
    check("rand_b_delivered", 64'(got_b), 64'(N_RAND));
    check("rand_a_left", 64'(qa.size()), 64'd0);
    check("rand_b_left", 64'(qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer. It replaces the fixed 32-bit enable-register between processor pipeline stages. It adds stall back-pressure, synchronous flush and full throughput: one transfer per cycle, with no combinational path from `out_ready` to `in_ready`. Every inter-stage latch in the datapath (IF/ID, ID/EX, EX/MEM, MEM/WB) is an instance of this block, sized by `WIDTH`.

## Interface
- `WIDTH`, 32, data bits carried per entry (must be at least 1).
- `RESET_VAL`, 0, value loaded into both data registers on reset (`WIDTH` bits).
- `clk` input 1 — rising-edge clock.
- `clr_n` input 1 — asynchronous, active-low reset.
- `flush` input 1 — synchronous discard of all held entries.
- `in_valid` input 1 — upstream presents `in_data`.
- `in_ready` output 1 — block accepts `in_data` this cycle.
- `in_data` input `WIDTH` — upstream payload.
- `out_valid` output 1 — `out_data` holds a valid entry.
- `out_ready` input 1 — downstream consumes `out_data` this cycle.
- `out_data` output `WIDTH` — payload held in the main register.
- `count` output 2 — occupancy, 0..2.

## Operation
- **Storage:** a main register (drives `out_data`) and a skid register, both `WIDTH` bits.
- **States:** EMPTY (count 0), BUSY (main valid, count 1), FULL (main and skid valid, count 2).
- **Outputs:**
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL).
  - All outputs are pure functions of registered state.
- **Transfers:** acc_in = `in_valid` & `in_ready`; acc_out = `out_valid` & `out_ready`.
- **EMPTY:**
  - acc_in → BUSY, main <= `in_data`.
  - Otherwise stay in EMPTY.
- **BUSY:**
  - acc_in & acc_out → BUSY, main <= `in_data`.
  - acc_in only → FULL, skid <= `in_data`.
  - acc_out only → EMPTY.
  - Neither → hold.
- **FULL:**
  - acc_out → BUSY, main <= skid.
  - Otherwise hold. No input is accepted because `in_ready` = 0.
- **Flush:** has priority over everything.
  - Next state is EMPTY.
  - Any same-cycle acc_in is discarded and the upstream beat is lost by design. Upstream treats it as consumed.
  - A same-cycle acc_out still counts as delivered.
  - Data registers are not written on a flush cycle.
- **Data registers:** written only on the transitions listed above. Otherwise they hold their value, including while EMPTY.
- **Ordering:** strict FIFO; the skid entry is never overtaken.

## Timing
- **Reset (`clr_n` low, asynchronous):**
  - state = EMPTY; main and skid = `RESET_VAL`.
  - Outputs: `out_valid` = 0, `in_ready` = 1, `count` = 0, `out_data` = `RESET_VAL`.
  - Reset release is synchronised externally; the block assumes it is clean.
- **Latency:** a beat accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N, i.e. 1 cycle.
- **Throughput:** 1 beat per cycle while `out_ready` stays high.
- **Stall:** after `out_ready` falls, the block absorbs at most one further beat. `in_ready` drops the cycle after that beat is taken.
- **Resume from FULL:** `in_ready` returns high one cycle after the first acc_out.
- **Reset mid-operation:** both entries are lost immediately; no partial update is permitted.
- **Undefined input:** `in_data` is don't-care when `in_valid` = 0. `out_data` is don't-care to consumers when `out_valid` = 0.

## Structure
- **Shared package `pipe_pkg`:**
  - 2-bit state encoding: EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2; `count` equals the state code.
  - Default `WIDTH` constant.
- **Sub-module `register_n`:**
  - Parametrised `WIDTH` register with enable and asynchronous active-low clear to `RESET_VAL`.
  - Instantiated twice: main and skid.
  - The 2-bit state register is inline.

## Test plan
- **Reset:** assert `clr_n` = 0 mid-stream while count = 2 → outputs immediately go to `out_valid` = 0, `in_ready` = 1, `count` = 0, `out_data` = `RESET_VAL`.
- **Streaming:** `out_ready` held 1; drive 0x1, 0x2, … 0x8 on consecutive cycles → 0x1..0x8 appear in order one cycle later, no bubbles, `count` stays at 1.
- **Stall and skid:**
  - Send 0xA, 0xB, 0xC with `out_ready` = 0 → 0xA and 0xB accepted, `count` = 2, `in_ready` = 0, 0xC held upstream.
  - Raise `out_ready` → output sequence is 0xA, 0xB, 0xC.
- **Flush in FULL:** `flush` = 1 with `in_valid` = 1 (0xD) and `out_ready` = 0 → next cycle `count` = 0, `out_valid` = 0; 0xD never appears at the output.
- **Flush with simultaneous drain:** in BUSY holding 0xE, `flush` = `out_ready` = 1 → 0xE counted as delivered once, then EMPTY.
- **Randomized back-pressure:** 1000 beats with random `in_valid` and `out_ready`, WIDTH = 1 and WIDTH = 64 → scoreboard shows no loss, duplication or reordering, and `in_ready` is never 1 while `count` = 2.
